stream_mux_nx1: RTL

- Parametrised N-to-1 stream multiplexer; generalises the 2:1 select mux to N_CH channels of WIDTH bits.
- Adds valid/ready handshake per channel and a registered output stage.
- Two selection modes: fixed select, or round-robin arbitration.
- Sits between multiple producer streams and a single consumer; one transfer per clock maximum.

---
 rtl/stream_mux_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/stream_mux_nx1.sv | 94 +++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and the rotating-priority pick for the N:1 stream mux.
// The mode encodings and the scan helper are common to the arbiter and the top level.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest channel count the pick helper supports.
    localparam int unsigned MAX_CH = 32;

    // Returns the first requesting index after 'last' (mod n_ch), or n_ch if none.
    function automatic int unsigned rr_pick(
        input logic [MAX_CH-1:0] req,
        input int unsigned       n_ch,
        input int unsigned       last
    );
        int unsigned idx;
        logic        found;
        rr_pick = n_ch;
        found   = 1'b0;
        for (int unsigned k = 1; k <= n_ch; k++) begin
            idx = (last + k) % n_ch;
            if (!found && req[idx[4:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req, rotating from the last
// accepted grant, which it records whenever advance is asserted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [SEL_W-1:0]  r_rr_last;
    logic [MAX_CH-1:0] w_req;
    int unsigned       w_pick;

    always_comb begin
        w_req             = '0;
        w_req[N_CH-1:0]   = req;
        w_pick            = rr_pick(w_req, N_CH, 32'(r_rr_last));
        grant_vld         = (w_pick < N_CH);
        grant_idx         = SEL_W'(w_pick);
    end

    // Reset to the last channel so channel 0 wins the first scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= SEL_W'(N_CH - 1);
        end else if (advance) begin
            r_rr_last <= grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin
// selection and a single registered output beat.
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;

    logic             w_can_load;
    logic             w_rr_vld;
    logic             w_grant_vld;
    logic             w_in_xfer;
    logic             w_advance;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_grant_idx;
    logic [N_CH-1:0]  w_grant_oh;
    logic [WIDTH-1:0] w_mux_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (w_advance),
        .grant_idx (w_rr_idx),
        .grant_vld (w_rr_vld)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            w_grant_idx = w_rr_idx;
            w_grant_vld = w_rr_vld;
        end else begin
            w_grant_idx = sel;
            w_grant_vld = (32'(sel) < N_CH);
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_mux_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_grant_vld && (w_grant_idx == SEL_W'(i))) begin
                w_grant_oh[i] = 1'b1;
                w_mux_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign in_ready   = (w_can_load && !rst) ? w_grant_oh : '0;
    assign w_in_xfer  = |(in_valid & in_ready);
    // Only round-robin traffic moves the rotation point.
    assign w_advance  = w_in_xfer && (mode == MODE_RR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_ch    <= w_grant_idx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule
